// File: rtl/binary_patch_streamer.sv
// Streams a binary raster frame through two line buffers and a 3x3 window, emitting complete patches.
// Optional build macro PATCH_STRIDE2_EN restricts output to windows with even top-left coordinates.
module binary_patch_streamer #(
   parameter int unsigned IMG_W = 8,
   parameter int unsigned IMG_H = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic                       weight_load,
   input  logic [8:0]                 weight_in,
   input  logic                       pix_valid,
   input  logic                       pix_bit,
   output logic                       pix_ready,
   output logic [8:0]                 patch_bits,
   output logic [8:0]                 weight_bits,
   output logic                       valid_out,
   output logic [$clog2(IMG_H)-1:0]   out_row,
   output logic [$clog2(IMG_W)-1:0]   out_col,
   output logic                       frame_done
);

   localparam int unsigned RW = $clog2(IMG_H);
   localparam int unsigned CW = $clog2(IMG_W);

   typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, DONE = 2'd2} state_t;

   state_t           state;
   logic [RW-1:0]    row;
   logic [CW-1:0]    col;
   logic [IMG_W-1:0] lb1;
   logic [IMG_W-1:0] lb2;
   logic [2:0]       top;
   logic [2:0]       mid;
   logic [2:0]       bot;

   logic             accept_c;
   logic             last_c;
   logic             emit_c;
   logic [2:0]       top_n_c;
   logic [2:0]       mid_n_c;
   logic [2:0]       bot_n_c;

   // pix_ready mirrors the ACTIVE state, so this is the handshake
   assign accept_c = pix_valid & pix_ready;
   assign last_c   = (row == RW'(IMG_H - 1)) && (col == CW'(IMG_W - 1));

   // Windows that wrap across a row boundary hold stale columns and are suppressed
`ifdef PATCH_STRIDE2_EN
   assign emit_c = (row >= RW'(2)) && (col >= CW'(2)) && !row[0] && !col[0];
`else
   assign emit_c = (row >= RW'(2)) && (col >= CW'(2));
`endif

   // Window rows after shifting in the new column; bit2 is the oldest column
   assign top_n_c = {top[1:0], lb2[col]};
   assign mid_n_c = {mid[1:0], lb1[col]};
   assign bot_n_c = {bot[1:0], pix_bit};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         row         <= '0;
         col         <= '0;
         lb1         <= '0;
         lb2         <= '0;
         top         <= '0;
         mid         <= '0;
         bot         <= '0;
         pix_ready   <= 1'b0;
         patch_bits  <= '0;
         weight_bits <= '0;
         valid_out   <= 1'b0;
         out_row     <= '0;
         out_col     <= '0;
         frame_done  <= 1'b0;
      end else begin
         valid_out  <= 1'b0;
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (weight_load) weight_bits <= weight_in;
               if (start) begin
                  state     <= ACTIVE;
                  row       <= '0;
                  col       <= '0;
                  pix_ready <= 1'b1;
               end
            end
            ACTIVE: begin
               if (accept_c) begin
                  top      <= top_n_c;
                  mid      <= mid_n_c;
                  bot      <= bot_n_c;
                  lb2[col] <= lb1[col];
                  lb1[col] <= pix_bit;
                  if (emit_c) begin
                     valid_out  <= 1'b1;
                     patch_bits <= {top_n_c, mid_n_c, bot_n_c};
                     out_row    <= row - RW'(2);
                     out_col    <= col - CW'(2);
                  end
                  if (col == CW'(IMG_W - 1)) begin
                     col <= '0;
                     row <= row + RW'(1);
                  end else begin
                     col <= col + CW'(1);
                  end
                  if (last_c) begin
                     state      <= DONE;
                     pix_ready  <= 1'b0;
                     frame_done <= 1'b1;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state     <= IDLE;
               pix_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_binary_patch_streamer.sv
// Directed/randomized bench for binary_patch_streamer against a frame-level window model.
module tb_binary_patch_streamer;

`ifdef PATCH_STRIDE2_EN
   localparam int STRIDE = 2;
   localparam logic [8:0] CB_SECOND = 9'b010101010;
`else
   localparam int STRIDE = 1;
   localparam logic [8:0] CB_SECOND = 9'b101010101;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       weight_load;
   logic [8:0] weight_in;
   logic       pix_valid;
   logic       pix_bit;
   logic       pix_ready;
   logic [8:0] patch_bits;
   logic [8:0] weight_bits;
   logic       valid_out;
   logic [2:0] out_row;
   logic [2:0] out_col;
   logic       frame_done;

   typedef struct {
      logic [8:0] p;
      logic [2:0] r;
      logic [2:0] c;
      logic       fd;
   } win_t;

   win_t obs[$];
   win_t exp_q[$];
   int   fd_cnt;
   int   total = 0;
   int   bad   = 0;
   bit   img[8][8];

   binary_patch_streamer #(.IMG_W(8), .IMG_H(8)) dut (
      .clk(clk), .reset(reset), .start(start), .weight_load(weight_load),
      .weight_in(weight_in), .pix_valid(pix_valid), .pix_bit(pix_bit),
      .pix_ready(pix_ready), .patch_bits(patch_bits), .weight_bits(weight_bits),
      .valid_out(valid_out), .out_row(out_row), .out_col(out_col),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   // Record every emitted window and every frame_done pulse
   always @(negedge clk) begin
      if (valid_out) obs.push_back('{p: patch_bits, r: out_row, c: out_col, fd: frame_done});
      if (frame_done) fd_cnt <= fd_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_ready"}, 32'(pix_ready), 32'd0);
      chk({tag, "_valid"}, 32'(valid_out), 32'd0);
      chk({tag, "_fdone"}, 32'(frame_done), 32'd0);
      chk({tag, "_patch"}, 32'(patch_bits), 32'd0);
      chk({tag, "_wbits"}, 32'(weight_bits), 32'd0);
      chk({tag, "_row"}, 32'(out_row), 32'd0);
      chk({tag, "_col"}, 32'(out_col), 32'd0);
   endtask

   task automatic do_start(input bit load, input logic [8:0] w);
      obs.delete();
      fd_cnt = 0;
      @(negedge clk);
      start = 1'b1; weight_load = load; weight_in = w;
      @(negedge clk);
      start = 1'b0; weight_load = 1'b0;
   endtask

   // Offer pixels in raster order until max_pix have been accepted
   task automatic run_frame(input bit gaps, input int max_pix, input int wl_at);
      int k = 0;
      int cyc = 0;
      bit wl_done = 0;
      while (k < max_pix && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         if (!wl_done && k == wl_at) begin
            weight_load = 1'b1; weight_in = 9'h0AA; wl_done = 1;
         end else begin
            weight_load = 1'b0;
         end
         pix_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         pix_bit   = img[k / 8][k % 8];
         if (pix_valid && pix_ready) k++;
      end
      @(posedge clk);
      #1 pix_valid = 1'b0; weight_load = 1'b0;
      if (k < max_pix) chk("stream_timeout", 32'(k), 32'(max_pix));
   endtask

   // Pixels offered after the frame must be ignored
   task automatic tail();
      pix_valid = 1'b1; pix_bit = 1'b1;
      repeat (4) @(negedge clk);
      pix_valid = 1'b0;
   endtask

   task automatic check_frame(input string tag);
      win_t w;
      exp_q.delete();
      for (int r = 0; r < 6; r++)
         for (int c = 0; c < 6; c++)
            if (r % STRIDE == 0 && c % STRIDE == 0) begin
               for (int i = 0; i < 3; i++)
                  for (int j = 0; j < 3; j++)
                     w.p[8 - (i * 3 + j)] = img[r + i][c + j];
               w.r  = 3'(r);
               w.c  = 3'(c);
               w.fd = (r == 5 && c == 5);
               exp_q.push_back(w);
            end
      chk({tag, "_count"}, 32'(obs.size()), 32'(exp_q.size()));
      chk({tag, "_fdcnt"}, 32'(fd_cnt), 32'd1);
      chk({tag, "_ready_after"}, 32'(pix_ready), 32'd0);
      for (int n = 0; n < obs.size() && n < exp_q.size(); n++) begin
         chk($sformatf("%s_w%0d_patch", tag, n), 32'(obs[n].p), 32'(exp_q[n].p));
         chk($sformatf("%s_w%0d_rc", tag, n), {obs[n].r, obs[n].c}, {exp_q[n].r, exp_q[n].c});
         chk($sformatf("%s_w%0d_fd", tag, n), 32'(obs[n].fd), 32'(exp_q[n].fd));
      end
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; weight_load = 1'b0; weight_in = '0;
      pix_valid = 1'b0; pix_bit = 1'b0; fd_cnt = 0;
      repeat (3) @(negedge clk);
      check_zero("reset");
      reset = 1'b1;

      // All-ones frame, kernel loaded together with start
      foreach (img[r, c]) img[r][c] = 1'b1;
      do_start(1'b1, 9'h1FF);
      chk("w_load_start", 32'(weight_bits), 32'h1FF);
      chk("ready_active", 32'(pix_ready), 32'd1);
      run_frame(1'b0, 64, -1);
      tail();
      check_frame("ones");

      // Checkerboard frame, kernel kept
      foreach (img[r, c]) img[r][c] = 1'((r + c) % 2);
      do_start(1'b0, 9'h000);
      chk("w_kept", 32'(weight_bits), 32'h1FF);
      run_frame(1'b0, 64, -1);
      tail();
      check_frame("cb");
      if (obs.size() >= 2) begin
         chk("cb_first", 32'(obs[0].p), 32'h0AA);
         chk("cb_second", 32'(obs[1].p), 32'(CB_SECOND));
      end

      // Random image with random pix_valid gaps and a mid-frame weight_load
      foreach (img[r, c]) img[r][c] = 1'($urandom_range(0, 1));
      do_start(1'b0, 9'h000);
      run_frame(1'b1, 64, 30);
      chk("w_midframe", 32'(weight_bits), 32'h1FF);
      tail();
      check_frame("gaps");
      chk("w_after_frame", 32'(weight_bits), 32'h1FF);
      @(negedge clk);
      weight_load = 1'b1; weight_in = 9'h0AA;
      @(negedge clk);
      weight_load = 1'b0;
      chk("w_reload_idle", 32'(weight_bits), 32'h0AA);

      // Abort after 20 accepted pixels
      foreach (img[r, c]) img[r][c] = 1'($urandom_range(0, 1));
      do_start(1'b0, 9'h000);
      run_frame(1'b0, 20, -1);
      #2 reset = 1'b0;
      #1 check_zero("abort");
      repeat (2) @(negedge clk);
      chk("abort_fdcnt", 32'(fd_cnt), 32'd0);
      reset = 1'b1;

      // Fresh frame after abort, kernel reloaded
      foreach (img[r, c]) img[r][c] = 1'($urandom_range(0, 1));
      do_start(1'b1, 9'h1FF);
      chk("w_after_abort", 32'(weight_bits), 32'h1FF);
      run_frame(1'b1, 64, -1);
      tail();
      check_frame("post");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/binary_patch_streamer.md
BINARY_PATCH_STREAMER -- requirements
Module: binary_patch_streamer

Interface
REQ-001 The block SHALL have parameter IMG_W, default 8, meaning feature-map width in pixels (legal range 3..256).
REQ-002 The block SHALL have parameter IMG_H, default 8, meaning feature-map height in pixels (legal range 3..256).
REQ-003 The block SHALL have port clk  input  1  rising-edge clock.
REQ-004 The block SHALL have port reset  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port start  input  1  single-cycle frame start request.
REQ-006 The block SHALL have port weight_load  input  1  capture weight_in.
REQ-007 The block SHALL have port weight_in  input  9  3x3 binary kernel.
REQ-008 The block SHALL have port pix_valid  input  1  pixel present.
REQ-009 The block SHALL have port pix_bit  input  1  binary pixel, raster order.
REQ-010 The block SHALL have port pix_ready  output  1  pixel accepted when pix_valid and pix_ready are both high.
REQ-011 The block SHALL have port patch_bits  output  9  3x3 window; bit8 = top-left, row-major, bit0 = bottom-right.
REQ-012 The block SHALL have port weight_bits  output  9  registered kernel, held constant for the whole frame.
REQ-013 The block SHALL have port valid_out  output  1  patch_bits is a complete window, one-cycle pulse per window.
REQ-014 The block SHALL have port out_row / out_col  output  $clog2(IMG_H) / $clog2(IMG_W)  top-left coordinate of the emitted window.
REQ-015 The block SHALL have port frame_done  output  1  one-cycle pulse at end of frame.

Function
REQ-016 The block SHALL implement states IDLE, ACTIVE and DONE: IDLE->ACTIVE on start; ACTIVE->DONE when pixel (IMG_H-1, IMG_W-1) is accepted; DONE->IDLE unconditionally after one cycle.
REQ-017 pix_ready SHALL be high only in ACTIVE; pixels offered in IDLE or DONE SHALL be ignored.
REQ-018 start SHALL be ignored in ACTIVE and DONE.
REQ-019 weight_load SHALL update the kernel register only in IDLE; if start and weight_load coincide in IDLE, the new weight SHALL be used for the starting frame.
REQ-020 The block SHALL keep col and row counters: col wraps from IMG_W-1 to 0 and increments row; both clear on entering ACTIVE.
REQ-021 The block SHALL hold two IMG_W-bit line buffers (rows r-1 and r-2) plus a 3x3 shift window, advancing only on accepted pixels.
REQ-022 On acceptance of pixel (r,c) with r>=2 and c>=2, the block SHALL assert valid_out on the next cycle, with patch_bits = rows r-2..r by cols c-2..c, out_row = r-2 and out_col = c-2.
REQ-023 Windows straddling a row wrap (c<2) SHALL never be emitted, even though the shift window holds stale columns.
REQ-024 A full frame SHALL emit exactly (IMG_H-2)*(IMG_W-2) windows.
REQ-025 patch_bits, out_row and out_col SHALL hold their last value while valid_out is low.
REQ-026 frame_done SHALL pulse in the DONE cycle, which coincides with the last valid_out of the frame.
REQ-027 pix_valid gaps SHALL stall the block with no lost or duplicated windows.

Reset
REQ-028 While reset is low, the block SHALL be in IDLE, clear both counters and both line buffers, and drive pix_ready=0, valid_out=0, frame_done=0, patch_bits=0, weight_bits=0, out_row=0 and out_col=0.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately with no frame_done; the next frame requires a new start and a weight reload.

Configuration
REQ-030 With macro PATCH_STRIDE2_EN defined, the block SHALL emit only windows whose out_row and out_col are both even, giving floor((IMG_H-1)/2)*floor((IMG_W-1)/2) windows per frame.
REQ-031 Without PATCH_STRIDE2_EN, the block SHALL use stride 1 as in REQ-022.

Verification
REQ-032 The bench SHALL load weight 9'h1FF, start, and stream an 8x8 all-ones frame with continuous pix_valid -> 36 valid_out pulses, each with patch_bits=9'h1FF, and frame_done coincident with the last pulse at out_row=5, out_col=5.
REQ-033 The bench SHALL stream an 8x8 checkerboard (pixel = (r+c) odd) -> window (0,0) has patch_bits=9'b010101010 and window (0,1) has patch_bits=9'b101010101, alternating thereafter.
REQ-034 The bench SHALL toggle pix_valid randomly at 50% over an 8x8 frame -> same 36 windows and coordinates as with continuous pix_valid; pix_ready=0 after frame_done.
REQ-035 The bench SHALL pulse weight_load with 9'h0AA mid-frame, then start a second frame -> weight_bits stays at the old value for the current frame and becomes 9'h0AA only after a reload in IDLE.
REQ-036 The bench SHALL pull reset low after 20 accepted pixels -> all outputs 0 within the same cycle, no frame_done; a new frame then yields the correct 36 windows.
REQ-037 The bench SHALL, with PATCH_STRIDE2_EN defined, stream an 8x8 frame -> 9 windows at out_row and out_col in {0,2,4}.
